level_generator: RTL and testbench

LEVEL_GENERATOR -- requirements
Module: level_generator

---
 rtl/level_generator_if.sv | 9 +
 rtl/level_generator.sv | 159 +++++++++++++++
 tb/tb_level_generator.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/level_generator_if.sv
// Edge-command handshake between a requester and level_generator.
interface level_generator_if;
    logic rise_req_i;
    logic fall_req_i;
    logic ready_o;

    modport master (output rise_req_i, output fall_req_i, input ready_o);
    modport slave  (input rise_req_i, input fall_req_i, output ready_o);
endinterface

// File: rtl/level_generator.sv
// Queues rise/fall commands and replays them onto level_o while enforcing
// minimum high and low phase lengths.
//
// state     | meaning
// IDLE_LOW  | level low, minimum low time met, pops a queued rise
// HOLD_LOW  | level low, counting down the minimum low time
// IDLE_HIGH | level high, minimum high time met, pops a queued fall
// HOLD_HIGH | level high, counting down the minimum high time
module level_generator #(
    parameter int MIN_HIGH = 3,
    parameter int MIN_LOW  = 2,
    parameter int DEPTH    = 4
) (
    input  logic               clk,
    input  logic               reset,
    level_generator_if.slave   cmd,
    output logic               level_o,
    output logic               rising_edge_o,
    output logic               falling_edge_o,
    output logic               err_o
);

    localparam int MAX_MIN = (MIN_HIGH > MIN_LOW) ? MIN_HIGH : MIN_LOW;
    localparam int CNT_W   = $clog2(MAX_MIN + 1);
    localparam int PTR_W   = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        HOLD_LOW  = 2'd1,
        IDLE_HIGH = 2'd2,
        HOLD_HIGH = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W:0]     cnt_ext;
    logic               level_q, level_d;
    logic               rise_e_q, rise_e_d;
    logic               fall_e_q, fall_e_d;
    logic               err_q, err_d;
    logic               tail_q, tail_d;
    logic [PTR_W:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]     rd_ptr_q, rd_ptr_d;
    logic [DEPTH-1:0]   mem_q, mem_d;

    logic fifo_full;
    logic fifo_empty;
    logic head;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign head       = mem_q[rd_ptr_q[PTR_W-1:0]];
    assign cnt_ext    = {1'b0, cnt_q};

    assign cmd.ready_o = reset && !fifo_full;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        level_d  = level_q;
        rise_e_d = 1'b0;
        fall_e_d = 1'b0;
        err_d    = 1'b0;
        tail_d   = tail_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;

        if (cmd.ready_o) begin
            if (cmd.rise_req_i && cmd.fall_req_i) begin
                err_d = 1'b1;
            end else if (cmd.rise_req_i ^ cmd.fall_req_i) begin
                // A command that would not change the queued-up level is dropped.
                if (cmd.rise_req_i == tail_q) begin
                    err_d = 1'b1;
                end else begin
                    mem_d[wr_ptr_q[PTR_W-1:0]] = cmd.rise_req_i;
                    wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
                    tail_d   = cmd.rise_req_i;
                end
            end
        end

        // The idle cycle before a pop is part of the phase, so each hold
        // exits with one count still owed to that idle cycle.
        case (state_q)
            IDLE_LOW: begin
                if (!fifo_empty && head) begin
                    rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
                    level_d  = 1'b1;
                    rise_e_d = 1'b1;
                    cnt_d    = CNT_W'(MIN_HIGH);
                    state_d  = HOLD_HIGH;
                end
            end
            HOLD_HIGH: begin
                if (cnt_ext <= (CNT_W+1)'(2)) begin
                    cnt_d   = '0;
                    state_d = IDLE_HIGH;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            IDLE_HIGH: begin
                if (!fifo_empty && !head) begin
                    rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
                    level_d  = 1'b0;
                    fall_e_d = 1'b1;
                    cnt_d    = CNT_W'(MIN_LOW);
                    state_d  = HOLD_LOW;
                end
            end
            HOLD_LOW: begin
                if (cnt_ext <= (CNT_W+1)'(2)) begin
                    cnt_d   = '0;
                    state_d = IDLE_LOW;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE_LOW;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE_LOW;
            cnt_q    <= '0;
            level_q  <= 1'b0;
            rise_e_q <= 1'b0;
            fall_e_q <= 1'b0;
            err_q    <= 1'b0;
            tail_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            mem_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            level_q  <= level_d;
            rise_e_q <= rise_e_d;
            fall_e_q <= fall_e_d;
            err_q    <= err_d;
            tail_q   <= tail_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

    assign level_o        = level_q;
    assign rising_edge_o  = rise_e_q;
    assign falling_edge_o = fall_e_q;
    assign err_o          = err_q;

endmodule

// File: tb/tb_level_generator.sv
// Directed bench for level_generator: a per-cycle vector table plus a
// reset-during-hold sequence, all with hand-computed expectations.
module tb_level_generator;

    logic clk = 1'b0;
    logic reset;
    logic level;
    logic rise_e;
    logic fall_e;
    logic err;

    int total = 0;
    int bad   = 0;

    level_generator_if intf ();

    level_generator #(
        .MIN_HIGH (3),
        .MIN_LOW  (2),
        .DEPTH    (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .cmd            (intf),
        .level_o        (level),
        .rising_edge_o  (rise_e),
        .falling_edge_o (fall_e),
        .err_o          (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic rst;
        logic rise;
        logic fall;
        logic rdy;
        logic lvl;
        logic re;
        logic fe;
        logic er;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic rise, input logic fall,
                       input logic rdy, input logic lvl, input logic re,
                       input logic fe, input logic er);
        vec_t v;
        v.rst = rst; v.rise = rise; v.fall = fall; v.rdy = rdy;
        v.lvl = lvl; v.re = re; v.fe = fe; v.er = er;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    // Drive one cycle, check ready_o before the edge and the registered
    // outputs just after it.
    task automatic step(input string tag, input logic rst, input logic rise,
                        input logic fall, input logic rdy, input logic lvl,
                        input logic re, input logic fe, input logic er);
        reset           = rst;
        intf.rise_req_i = rise;
        intf.fall_req_i = fall;
        #1;
        chk({tag, " ready_o"}, intf.ready_o, rdy);
        @(posedge clk);
        #1;
        chk({tag, " level_o"}, level, lvl);
        chk({tag, " rising_edge_o"}, rise_e, re);
        chk({tag, " falling_edge_o"}, fall_e, fe);
        chk({tag, " err_o"}, err, er);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset           = 1'b0;
        intf.rise_req_i = 1'b0;
        intf.fall_req_i = 1'b0;

        //  rst rise fall | rdy lvl re fe err
        add(0, 0, 0,  0, 0, 0, 0, 0);   // edge 1: reset
        add(0, 1, 0,  0, 0, 0, 0, 0);   // edge 2: reset beats request
        add(1, 0, 0,  1, 0, 0, 0, 0);
        add(1, 0, 0,  1, 0, 0, 0, 0);
        add(1, 1, 0,  1, 0, 0, 0, 0);   // edge 5: rise accepted
        add(1, 0, 1,  1, 1, 1, 0, 0);   // edge 6: level up, fall queued
        add(1, 0, 0,  1, 1, 0, 0, 0);
        add(1, 0, 0,  1, 1, 0, 0, 0);
        add(1, 0, 0,  1, 0, 0, 1, 0);   // edge 9: falls after 3 high cycles
        add(1, 0, 0,  1, 0, 0, 0, 0);
        add(1, 0, 0,  1, 0, 0, 0, 0);
        add(1, 1, 1,  1, 0, 0, 0, 1);   // both requests rejected
        add(1, 0, 0,  1, 0, 0, 0, 0);
        add(1, 0, 0,  1, 0, 0, 0, 0);
        add(1, 0, 1,  1, 0, 0, 0, 1);   // fall while already low
        add(1, 0, 0,  1, 0, 0, 0, 0);
        add(1, 1, 0,  1, 0, 0, 0, 0);   // rise accepted
        add(1, 1, 0,  1, 1, 1, 0, 1);   // second rise rejected
        add(1, 0, 0,  1, 1, 0, 0, 0);
        add(1, 0, 0,  1, 1, 0, 0, 0);
        add(1, 0, 0,  1, 1, 0, 0, 0);
        add(1, 0, 0,  1, 1, 0, 0, 0);   // no second rising strobe
        add(1, 0, 1,  1, 1, 0, 0, 0);   // fill: F
        add(1, 1, 0,  1, 0, 0, 1, 0);   // R, F popped
        add(1, 0, 1,  1, 0, 0, 0, 0);   // F
        add(1, 1, 0,  1, 1, 1, 0, 0);   // R, R popped
        add(1, 0, 1,  1, 1, 0, 0, 0);   // F
        add(1, 1, 0,  1, 1, 0, 0, 0);   // R -> full
        add(1, 1, 0,  0, 0, 0, 1, 0);   // blocked request, pop while full
        add(1, 0, 0,  1, 0, 0, 0, 0);
        add(1, 0, 0,  1, 1, 1, 0, 0);   // drain at 2-low/3-high spacing
        add(1, 0, 0,  1, 1, 0, 0, 0);
        add(1, 0, 0,  1, 1, 0, 0, 0);
        add(1, 0, 0,  1, 0, 0, 1, 0);
        add(1, 0, 0,  1, 0, 0, 0, 0);
        add(1, 0, 0,  1, 1, 1, 0, 0);
        add(1, 0, 0,  1, 1, 0, 0, 0);
        add(1, 0, 0,  1, 1, 0, 0, 0);
        add(1, 0, 0,  1, 1, 0, 0, 0);   // queue empty, level stays
        add(1, 0, 0,  1, 1, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step($sformatf("vec%0d", i + 1), vecs[i].rst, vecs[i].rise,
                 vecs[i].fall, vecs[i].rdy, vecs[i].lvl, vecs[i].re,
                 vecs[i].fe, vecs[i].er);
        end

        // Reset in HOLD_HIGH with two commands queued.
        step("rh1",  1, 0, 1,  1, 1, 0, 0, 0);
        step("rh2",  1, 1, 0,  1, 0, 0, 1, 0);
        step("rh3",  1, 0, 1,  1, 0, 0, 0, 0);
        step("rh4",  1, 1, 0,  1, 1, 1, 0, 0);
        step("rh5",  0, 1, 0,  0, 0, 0, 0, 0);
        step("rh6",  1, 0, 0,  1, 0, 0, 0, 0);
        step("rh7",  1, 0, 0,  1, 0, 0, 0, 0);
        step("rh8",  1, 0, 0,  1, 0, 0, 0, 0);
        step("rh9",  1, 1, 0,  1, 0, 0, 0, 0);
        step("rh10", 1, 0, 0,  1, 1, 1, 0, 0);
        step("rh11", 1, 0, 0,  1, 1, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
